xor_operand_feeder: RTL and testbench
=====================================

// Module: xor_operand_feeder
// PURPOSE
//  Upstream feeder for the N-bit bitwise XOR array (f = a ^ b).
//  Accepts a data word stream on a valid/ready handshake and pairs each word with an N-bit LFSR keystream word.
//  Presents the pair as registered operands out_a/out_b, ready to drive the XOR array's a/b inputs (scrambler path).
//  Holds a one-entry output register with full-throughput backpressure.
// PARAMETERS
//  N     16        data / keystream / LFSR width in bits
//  POLY  16'hB400  Galois feedback mask (x^16+x^14+x^13+x^11+1)
//  SEED  16'hACE1  LFSR reset value; also substituted for any all-zero seed load
//  STEPS 1         LFSR steps taken per accepted word (1..N)
// PORTS
//  clk        in   1   rising-edge clock
//  rst_n      in   1   asynchronous active-low reset
//  load       in   1   load LFSR from seed this cycle
//  seed       in   N   seed value (all-zero replaced by SEED)
//  scr_en     in   1   1: out_b = keystream; 0: out_b = 0, LFSR frozen (bypass)
//  in_valid   in   1   in_data valid
//  in_ready   out  1   feeder can accept in_data this cycle
//  in_data    in   N   data word -> becomes out_a
//  out_valid  out  1   out_a/out_b hold a valid pair
//  out_ready  in   1   consumer takes the pair this cycle
//  out_a      out  N   registered data operand
//  out_b      out  N   registered keystream operand
//  word_cnt   out  16  count of pairs accepted since reset/load, wraps 16'hFFFF->0
// BEHAVIOUR
//  Reset (async, rst_n=0): out_valid=0, out_a=0, out_b=0, word_cnt=0, lfsr=SEED. in_ready=0 while rst_n=0.
//  LFSR step (Galois, right shift): lsb=s[0]; s=s>>1; if (lsb) s=s^POLY. One word advance = STEPS steps, combinational.
//  in_ready = rst_n & !load & (!out_valid | out_ready). Load is never granted in the same cycle as a transfer.
//  Accept (in_valid & in_ready), next edge:
//   out_a<=in_data; out_b<=scr_en ? lfsr : 0; out_valid<=1; word_cnt<=word_cnt+1.
//   If scr_en=1, lfsr<=advance(lfsr); otherwise lfsr unchanged.
//  Pop without accept (out_valid & out_ready & !accept): out_valid<=0; out_a/out_b keep their old values.
//  Stall (out_valid & !out_ready): out_a, out_b, out_valid, lfsr, word_cnt all hold. in_ready=0.
//  Simultaneous pop + accept: new pair loaded with no bubble; one word per cycle sustained.
//  Load: lfsr<=(seed==0)?SEED:seed; word_cnt<=0.
//   The pending output pair, if any, is untouched and still drains normally.
//  Latency: in_data accepted at edge k appears on out_a with out_valid=1 after edge k (1 cycle).
//  Keystream of the first word after reset/load is the seed itself, not the advanced state.
//  LFSR never reaches all-zero: the zero seed is substituted and POLY is primitive. Period is 2^N-1 steps.
//  out_valid never drops without a pop; out_a/out_b are stable while out_valid & !out_ready.
// TESTING
//  T1 reset: rst_n=0 mid-stream, out_valid=1 -> out_valid=0, out_a=out_b=0, word_cnt=0 immediately (async).
//   After release, the next keystream word is 16'hACE1.
//  T2 keystream: STEPS=1, scr_en=1, out_ready=1, in_data=16'haaaa then 16'h0f0f ->
//   Pairs (aaaa,ACE1) then (0f0f,E270); word_cnt=2.
//  T3 backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0.
//   First pair held stable, LFSR frozen; the second word enters on the cycle out_ready returns, with no bubble.
//  T4 seed load: load=1, seed=0 -> next keystream 16'hACE1, word_cnt=0, in_ready=0 during load cycle.
//   load=1, seed=16'h1234 -> next keystream 16'h1234.
//  T5 bypass: scr_en=0, in_data=16'h00ff -> out_b=0, LFSR unchanged.
//   Re-enable -> keystream resumes from the frozen state.
//  T6 throughput/wrap: 65536 back-to-back words -> one per cycle, word_cnt wraps to 0.
//   The LFSR returns to SEED after 65535 steps (STEPS=1).

Source files
------------

// File: rtl/xor_operand_feeder_if.sv
// xor_operand_feeder_if: stream, control and operand bundle between the feeder and its neighbours.
interface xor_operand_feeder_if #(parameter int N = 16);
    logic         load;
    logic [N-1:0] seed;
    logic         scr_en;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_a;
    logic [N-1:0] out_b;
    logic [15:0]  word_cnt;
    modport master (
        output load, seed, scr_en, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_a, out_b, word_cnt
    );
    modport slave (
        input  load, seed, scr_en, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_a, out_b, word_cnt
    );
endinterface

// File: rtl/xor_operand_feeder.sv
// xor_operand_feeder: pairs each accepted data word with a Galois LFSR keystream word
// and holds the pair in a one-entry output register with full-throughput backpressure.
module xor_operand_feeder #(
    parameter int           N     = 16,
    parameter logic [N-1:0] POLY  = 16'hB400,
    parameter logic [N-1:0] SEED  = 16'hACE1,
    parameter int           STEPS = 1
) (
    input logic clk,
    input logic rst_n,
    xor_operand_feeder_if.slave bus
);
    logic [N-1:0] lfsr_q, lfsr_d, a_q, a_d, b_q, b_d;
    logic         valid_q, valid_d, accept;
    logic [15:0]  cnt_q, cnt_d;

    function automatic logic [N-1:0] advance(input logic [N-1:0] s);
        logic [N-1:0] t;
        t = s;
        for (int i = 0; i < STEPS; i++) t = t[0] ? (t >> 1) ^ POLY : t >> 1;
        return t;
    endfunction

    // Load blocks acceptance, so seeding and keystream use never collide.
    assign bus.in_ready  = rst_n & ~bus.load & (~valid_q | bus.out_ready);
    assign accept        = bus.in_valid & bus.in_ready;
    assign bus.out_valid = valid_q;
    assign bus.out_a     = a_q;
    assign bus.out_b     = b_q;
    assign bus.word_cnt  = cnt_q;

    always_comb begin
        valid_d = accept | (valid_q & ~bus.out_ready);
        a_d     = accept ? bus.in_data : a_q;
        b_d     = accept ? (bus.scr_en ? lfsr_q : '0) : b_q;
        lfsr_d  = bus.load ? ((bus.seed == '0) ? SEED : bus.seed)
                : (accept & bus.scr_en) ? advance(lfsr_q) : lfsr_q;
        cnt_d   = bus.load ? 16'd0 : accept ? cnt_q + 16'd1 : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q  <= SEED;
            a_q     <= '0;
            b_q     <= '0;
            valid_q <= 1'b0;
            cnt_q   <= 16'd0;
        end else begin
            lfsr_q  <= lfsr_d;
            a_q     <= a_d;
            b_q     <= b_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_xor_operand_feeder.sv
// tb_xor_operand_feeder: randomized and directed traffic checked against a transaction-level model.
module tb_xor_operand_feeder;
    localparam logic [15:0] POLY = 16'hB400;
    localparam logic [15:0] SEED = 16'hACE1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    xor_operand_feeder_if #(.N(16)) bus ();
    xor_operand_feeder dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // Reference state: current keystream word, held pair, count.
    logic [15:0] m_key, m_a, m_b, m_cnt;
    logic        m_valid;

    function automatic logic [15:0] next_key(input logic [15:0] s);
        return (s % 2 == 1) ? ((s / 2) ^ POLY) : (s / 2);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_key = SEED; m_a = 0; m_b = 0; m_cnt = 0; m_valid = 0;
    endtask

    task automatic step(input logic ld, input logic [15:0] sd, input logic se,
                        input logic iv, input logic [15:0] d, input logic ordy);
        logic exp_rdy, acc;
        bus.load = ld; bus.seed = sd; bus.scr_en = se;
        bus.in_valid = iv; bus.in_data = d; bus.out_ready = ordy;
        #1;
        exp_rdy = !ld && (!m_valid || ordy);
        check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        acc = iv && exp_rdy;
        if (acc) begin
            m_a = d;
            m_b = se ? m_key : 16'h0;
            m_cnt = m_cnt + 16'd1;
            if (se) m_key = next_key(m_key);
        end
        m_valid = acc || (m_valid && !ordy);
        if (ld) begin
            m_key = (sd == 0) ? SEED : sd;
            m_cnt = 0;
        end
        @(posedge clk);
        #1;
        check("out_valid", 32'(bus.out_valid), 32'(m_valid));
        check("out_a", 32'(bus.out_a), 32'(m_a));
        check("out_b", 32'(bus.out_b), 32'(m_b));
        check("word_cnt", 32'(bus.word_cnt), 32'(m_cnt));
    endtask

    task automatic idle();
        step(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b1);
    endtask

    initial begin
        bus.load = 0; bus.seed = 0; bus.scr_en = 1; bus.in_valid = 0;
        bus.in_data = 0; bus.out_ready = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(bus.out_valid), 0);
        check("rst_in_ready", 32'(bus.in_ready), 0);
        check("rst_cnt", 32'(bus.word_cnt), 0);
        rst_n = 1'b1;

        // keystream: first two words after reset
        step(0, 0, 1, 1, 16'haaaa, 1);
        check("t2_b0", 32'(bus.out_b), 32'h0000ACE1);
        step(0, 0, 1, 1, 16'h0f0f, 1);
        check("t2_b1", 32'(bus.out_b), 32'h0000E270);
        check("t2_cnt", 32'(bus.word_cnt), 2);

        // backpressure: hold three cycles, then pop+accept without bubble
        repeat (3) step(0, 0, 1, 1, 16'h5555, 0);
        check("t3_hold_a", 32'(bus.out_a), 32'h00000f0f);
        step(0, 0, 1, 1, 16'h5555, 1);
        check("t3_next_a", 32'(bus.out_a), 32'h00005555);

        // seed load: zero seed substitutes SEED; pending pair still drains
        step(0, 0, 1, 1, 16'h1111, 0);
        step(1, 16'h0000, 1, 1, 16'h2222, 0);
        check("t4_cnt0", 32'(bus.word_cnt), 0);
        step(0, 0, 1, 1, 16'h3333, 1);
        check("t4_key_seed", 32'(bus.out_b), 32'h0000ACE1);
        step(1, 16'h1234, 1, 0, 16'h0, 1);
        step(0, 0, 1, 1, 16'h4444, 1);
        check("t4_key_1234", 32'(bus.out_b), 32'h00001234);

        // bypass: out_b zero, keystream frozen, then resumes
        step(0, 0, 0, 1, 16'h00ff, 1);
        check("t5_bypass_b", 32'(bus.out_b), 0);
        check("t5_bypass_a", 32'(bus.out_a), 32'h000000ff);
        step(0, 0, 1, 1, 16'h0001, 1);
        check("t5_resume", 32'(bus.out_b), 32'(next_key(16'h1234)));

        // async reset mid-stream with a held pair
        step(0, 0, 1, 1, 16'hbeef, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t1_valid", 32'(bus.out_valid), 0);
        check("t1_a", 32'(bus.out_a), 0);
        check("t1_b", 32'(bus.out_b), 0);
        check("t1_cnt", 32'(bus.word_cnt), 0);
        check("t1_in_ready", 32'(bus.in_ready), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(0, 0, 1, 1, 16'h7777, 1);
        check("t1_key_after", 32'(bus.out_b), 32'h0000ACE1);

        // randomized mix
        for (int i = 0; i < 2000; i++) begin
            logic [15:0] sd;
            sd = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            step(1'($urandom_range(0, 19) == 0), sd, 1'($urandom_range(0, 4) != 0),
                 1'($urandom_range(0, 3) != 0), 16'($urandom), 1'($urandom_range(0, 2) != 0));
        end

        // throughput and wrap: full LFSR period and counter wrap
        step(1, 16'h0000, 1, 0, 16'h0, 1);
        idle();
        for (int i = 0; i < 65536; i++) step(0, 0, 1, 1, 16'(i), 1);
        check("t6_cnt_wrap", 32'(bus.word_cnt), 0);
        check("t6_period", 32'(bus.out_b), 32'h0000ACE1);
        check("t6_last_a", 32'(bus.out_a), 32'h0000FFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
